// File: rtl/coprime_checker.sv
// coprime_checker: iterative binary (Stein) GCD engine that reports whether two
// 32-bit unsigned operands are coprime.
//
// Optional feature macro: COPRIME_GCD_PORT_EN
//   defined   -> gcd_out port present, registered at terminate
//   undefined -> gcd_out port and register removed; cycle behaviour unchanged
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request strobe, sampled only while idle
//   num1     in   32  operand A, captured on accepted start
//   num2     in   32  operand B, captured on accepted start
//   busy     out  1   high while reducing
//   done     out  1   one-cycle result-valid pulse
//   coprime  out  1   1 iff gcd(num1, num2) == 1; held until next done
//   gcd_out  out  32  gcd of the captured operands (macro-enabled only)
module coprime_checker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic        busy,
    output logic        done,
    output logic        coprime
`ifdef COPRIME_GCD_PORT_EN
    ,
    output logic [31:0] gcd_out
`endif
);

    typedef enum logic {StIdle, StReduce} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [5:0]  k_q, k_d;
    logic        done_q, done_d;
    logic        coprime_q, coprime_d;
    logic [31:0] result;
    logic        term;

`ifdef COPRIME_GCD_PORT_EN
    logic [31:0] gcd_q, gcd_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        done_d    = 1'b0;
        coprime_d = coprime_q;
        result    = '0;
        term      = 1'b0;
`ifdef COPRIME_GCD_PORT_EN
        gcd_d     = gcd_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = num1;
                    b_d     = num2;
                    k_d     = '0;
                    state_d = StReduce;
                end
            end
            StReduce: begin
                if (a_q == '0) begin
                    result = b_q << k_q;
                    term   = 1'b1;
                end else if (b_q == '0) begin
                    result = a_q << k_q;
                    term   = 1'b1;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 6'd1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q >= b_q) begin
                    // Difference of two odds is even, so the halving loses nothing.
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end

                if (term) begin
                    coprime_d = (result == 32'd1);
                    done_d    = 1'b1;
                    state_d   = StIdle;
`ifdef COPRIME_GCD_PORT_EN
                    gcd_d     = result;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            coprime_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            k_q       <= k_d;
            done_q    <= done_d;
            coprime_q <= coprime_d;
        end
    end

`ifdef COPRIME_GCD_PORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcd_q <= '0;
        end else begin
            gcd_q <= gcd_d;
        end
    end

    assign gcd_out = gcd_q;
`endif

    assign busy    = (state_q == StReduce);
    assign done    = done_q;
    assign coprime = coprime_q;

endmodule

// File: tb/tb_coprime_checker.sv
// Self-checking bench for coprime_checker: directed and randomized operand
// pairs compared against a Euclid-based gcd reference model.
module tb_coprime_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        busy;
    logic        done;
    logic        coprime;
`ifdef COPRIME_GCD_PORT_EN
    logic [31:0] gcd_out;
`endif

    int tests = 0;
    int fails = 0;

    coprime_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .num1    (num1),
        .num2    (num2),
        .busy    (busy),
        .done    (done),
        .coprime (coprime)
`ifdef COPRIME_GCD_PORT_EN
        ,
        .gcd_out (gcd_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        num1  = a;
        num2  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called one cycle after the start edge; returns with done sampled high
    // (or after the bound expires, counted as a failure).
    task automatic wait_done(input string tag, output int cyc);
        cyc = 1;
        while (!done && cyc < 70) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency_le66"}, {31'd0, (cyc <= 66)}, 32'd1);
        chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] g;
        g = ref_gcd(a, b);
        chk({tag, "_coprime"}, {31'd0, coprime}, {31'd0, (g == 32'd1)});
`ifdef COPRIME_GCD_PORT_EN
        chk({tag, "_gcd"}, gcd_out, g);
`endif
    endtask

    task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        issue(a, b);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(tag, cyc);
        check_result(tag, a, b);
        tick();
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int ndone;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        num1  = '0;
        num2  = '0;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_coprime", {31'd0, coprime}, 32'd0);
`ifdef COPRIME_GCD_PORT_EN
        chk("reset_gcd", gcd_out, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // Directed pairs
        run_pair("p17_23", 32'd17, 32'd23);
        run_pair("p12_18", 32'd12, 32'd18);
        run_pair("p0_1", 32'd0, 32'd1);
        run_pair("p0_5", 32'd0, 32'd5);
        run_pair("p0_0", 32'd0, 32'd0);
        run_pair("pmax", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_pair("ppow2", 32'h8000_0000, 32'h4000_0000);
        run_pair("p1_1", 32'd1, 32'd1);

        // Restart during computation is ignored
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        num1  = 32'd12;
        num2  = 32'd18;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        cyc = 3;
        while (!done && cyc < 70) begin
            tick();
            cyc++;
        end
        chk("ignore_done_seen", {31'd0, done}, 32'd1);
        check_result("ignore", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("ignore_no_extra_done", ndone, 32'd0);

        // Asynchronous reset mid-computation (coprime currently 1)
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) tick();
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_coprime", {31'd0, coprime}, 32'd0);
`ifdef COPRIME_GCD_PORT_EN
        chk("rst_gcd", gcd_out, 32'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("rst_no_done", ndone, 32'd0);
        run_pair("post_rst", 32'd21, 32'd14);

        // Back-to-back: new start in the done cycle
        issue(32'd12, 32'd18);
        wait_done("b2b_first", cyc);
        check_result("b2b_first", 32'd12, 32'd18);
        issue(32'd35, 32'd64);
        chk("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        check_result("b2b_hold_old", 32'd12, 32'd18);
        wait_done("b2b_second", cyc);
        check_result("b2b_second", 32'd35, 32'd64);
        tick();

        // Randomized pairs, some sharing powers of two
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) begin
                ra = ra << $urandom_range(0, 12);
                rb = rb << $urandom_range(0, 12);
            end else if (i % 4 == 2) begin
                ra = $urandom_range(0, 40);
                rb = $urandom_range(0, 40);
            end
            run_pair($sformatf("rnd%0d", i), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
